// File: rtl/compound_rx.sv
// compound_rx: receiving end of the CompoundType link.
// A record is taken from the blocking b_in port (sync/notify handshake) and
// processed in the next cycle. Write records add +/-x to a signed accumulator,
// read records bump a read counter. Each processed record raises res_notify for
// one cycle, together with a match flag against the shadow input m_in.
// Build option: define COMPOUND_RX_SAT_EN to make the accumulator and the read
// counter saturate instead of wrapping.

package testbasic21_types;
    typedef enum logic {MODE_READ = 1'b0, MODE_WRITE = 1'b1} mode_t;

    typedef struct packed {
        mode_t              mode;
        logic signed [31:0] x;
        logic               y;
    } CompoundType;
endpackage

// state     | meaning
// ----------+------------------------------------------------------------
// SEC_RECV  | ready (b_in_notify=1), latch b_in when b_in_sync is high
// SEC_PROC  | one cycle: apply latched record, sample m_in, raise res_notify
module compound_rx
    import testbasic21_types::*;
#(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  CompoundType             b_in,
    input  logic                    b_in_sync,
    output logic                    b_in_notify,
    input  CompoundType             m_in,
    output logic signed [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0]        rd_count,
    output logic                    match_out,
    output logic                    res_notify
);

    typedef enum logic {SEC_RECV = 1'b0, SEC_PROC = 1'b1} section_t;

    section_t    section;
    section_t    section_nxt;
    CompoundType rx;
    logic        take_rec;
    logic        do_proc;

    logic signed [ACC_W:0]   x_ext;
    logic signed [ACC_W:0]   delta;
    logic signed [ACC_W:0]   acc_ext;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic                    match_nxt;

    // The mode of the shadow copy takes no part in the match.
    logic m_mode_unused;
    assign m_mode_unused = m_in.mode;

    // Section register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            section <= SEC_RECV;
        end else begin
            section <= section_nxt;
        end
    end

    // Next section and handshake; b_in_sync is ignored while processing.
    always_comb begin
        section_nxt = section;
        b_in_notify = 1'b0;
        take_rec    = 1'b0;
        do_proc     = 1'b0;
        case (section)
            SEC_RECV: begin
                b_in_notify = 1'b1;
                if (b_in_sync) begin
                    take_rec    = 1'b1;
                    section_nxt = SEC_PROC;
                end
            end
            SEC_PROC: begin
                do_proc     = 1'b1;
                section_nxt = SEC_RECV;
            end
            default: section_nxt = SEC_RECV;
        endcase
    end

    // Arithmetic is one bit wider than the accumulator so that negating
    // x = -2^31 is exact and overflow is visible in the top two bits.
    always_comb begin
        x_ext     = {{(ACC_W + 1 - 32){rx.x[31]}}, rx.x};
        delta     = rx.y ? -x_ext : x_ext;
        acc_ext   = {acc_out[ACC_W-1], acc_out};
        sum       = acc_ext + delta;
        match_nxt = (rx.x == m_in.x) && (rx.y == m_in.y);
`ifdef COMPOUND_RX_SAT_EN
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            acc_nxt = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            acc_nxt = sum[ACC_W-1:0];
        end
        cnt_nxt = (&rd_count) ? rd_count : rd_count + CNT_W'(1);
`else
        acc_nxt = sum[ACC_W-1:0];
        cnt_nxt = rd_count + CNT_W'(1);
`endif
    end

    // Record latch, result registers and result strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx         <= '{mode: MODE_READ, x: '0, y: 1'b0};
            acc_out    <= '0;
            rd_count   <= '0;
            match_out  <= 1'b0;
            res_notify <= 1'b0;
        end else begin
            res_notify <= do_proc;
            if (take_rec) begin
                rx <= b_in;
            end
            if (do_proc) begin
                match_out <= match_nxt;
                if (rx.mode == MODE_WRITE) begin
                    acc_out <= acc_nxt;
                end else begin
                    rd_count <= cnt_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_compound_rx.sv
// Testbench for compound_rx: idle check, directed vector table, continuous
// sync sequence, randomized records against a reference model, reset mid-record.
// Two instances share stimulus: default widths and a 2-bit read counter.
module tb_compound_rx;
    import testbasic21_types::*;

`ifdef COMPOUND_RX_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    CompoundType b_in;
    logic        b_in_sync;
    CompoundType m_in;

    logic        b_in_notify;
    logic [31:0] acc_out;
    logic [15:0] rd_count;
    logic        match_out;
    logic        res_notify;

    logic        b_in_notify_c2;
    logic [31:0] acc_out_c2;
    logic [1:0]  rd_count_c2;
    logic        match_out_c2;
    logic        res_notify_c2;

    compound_rx dut (
        .clk(clk), .rst(rst), .b_in(b_in), .b_in_sync(b_in_sync),
        .b_in_notify(b_in_notify), .m_in(m_in), .acc_out(acc_out),
        .rd_count(rd_count), .match_out(match_out), .res_notify(res_notify)
    );

    compound_rx #(.ACC_W(32), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .b_in(b_in), .b_in_sync(b_in_sync),
        .b_in_notify(b_in_notify_c2), .m_in(m_in), .acc_out(acc_out_c2),
        .rd_count(rd_count_c2), .match_out(match_out_c2), .res_notify(res_notify_c2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    longint acc_m;
    longint rd_m;
    logic   match_m;

    typedef struct {
        bit          rst_before;
        CompoundType rec;
        logic [31:0] mx;
        logic        my;
        logic [31:0] e_acc;
        logic [15:0] e_rd;
        logic [1:0]  e_rd2;
        logic        e_match;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        b_in_sync = 1'b0;
        tick();
        tick();
        rst   = 1'b0;
        acc_m = 0;
        rd_m  = 0;
        match_m = 1'b0;
    endtask

    function automatic CompoundType junk_rec();
        CompoundType r;
        r.mode = ($urandom_range(0, 1) == 1) ? MODE_WRITE : MODE_READ;
        r.x    = $urandom;
        r.y    = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Reference: plain integer arithmetic then wrap or clamp to the output range.
    task automatic model_apply(input CompoundType rec, input logic [31:0] mx, input logic my);
        longint xv;
        xv = longint'(signed'(rec.x));
        if (rec.mode == MODE_WRITE) begin
            acc_m = rec.y ? acc_m - xv : acc_m + xv;
            if (SAT) begin
                if (acc_m > 64'sd2147483647)  acc_m = 64'sd2147483647;
                if (acc_m < -64'sd2147483648) acc_m = -64'sd2147483648;
            end else begin
                acc_m = (((acc_m + 64'sd2147483648) % 64'sd4294967296) + 64'sd4294967296)
                        % 64'sd4294967296 - 64'sd2147483648;
            end
        end else begin
            rd_m = rd_m + 1;
        end
        match_m = (rec.x == mx) && (rec.y == my);
    endtask

    function automatic logic [31:0] exp_rd(input longint total, input longint modulus);
        if (SAT) return (total >= modulus) ? 32'(modulus - 1) : 32'(total);
        return 32'(total % modulus);
    endfunction

    // Transfers rec, leaves the bench just after the processing edge.
    // m_in is junk until after the transfer, proving it is sampled in processing.
    task automatic send(input CompoundType rec, input logic [31:0] mx, input logic my,
                        input bit hold_sync);
        check("notify_ready", 32'(b_in_notify), 32'd1);
        b_in      = rec;
        b_in_sync = 1'b1;
        m_in      = junk_rec();
        tick();
        check("notify_low_t0", 32'(b_in_notify), 32'd0);
        check("res_low_t0", 32'(res_notify), 32'd0);
        b_in_sync = hold_sync;
        if (hold_sync) b_in = junk_rec();
        m_in.mode = (rec.mode == MODE_READ) ? MODE_WRITE : MODE_READ;
        m_in.x    = mx;
        m_in.y    = my;
        tick();
        b_in_sync = 1'b0;
        check("res_pulse_t1", 32'(res_notify), 32'd1);
        check("notify_back_t1", 32'(b_in_notify), 32'd1);
    endtask

    function automatic CompoundType mk(input mode_t md, input logic [31:0] x, input logic y);
        CompoundType r;
        r.mode = md;
        r.x    = x;
        r.y    = y;
        return r;
    endfunction

    initial begin
        rst       = 1'b1;
        b_in_sync = 1'b0;
        b_in      = mk(MODE_READ, 32'd0, 1'b0);
        m_in      = mk(MODE_READ, 32'd0, 1'b0);

        tbl[0]  = '{1'b1, mk(MODE_WRITE, 32'd5, 1'b0), 32'd3, 1'b1, 32'd5, 16'd0, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, mk(MODE_WRITE, 32'd3, 1'b1), 32'd3, 1'b1, 32'd2, 16'd0, 2'd0, 1'b1};
        tbl[2]  = '{1'b0, mk(MODE_READ, 32'd3, 1'b1), 32'd3, 1'b1, 32'd2, 16'd1, 2'd1, 1'b1};
        tbl[3]  = '{1'b0, mk(MODE_READ, 32'd7, 1'b0), 32'd7, 1'b1, 32'd2, 16'd2, 2'd2, 1'b0};
        tbl[4]  = '{1'b0, mk(MODE_READ, 32'hFFFFFFFC, 1'b1), 32'hFFFFFFFC, 1'b1, 32'd2, 16'd3, 2'd3, 1'b1};
        tbl[5]  = '{1'b0, mk(MODE_READ, 32'd0, 1'b0), 32'd1, 1'b0, 32'd2, 16'd4, SAT ? 2'd3 : 2'd0, 1'b0};
        tbl[6]  = '{1'b0, mk(MODE_READ, 32'd0, 1'b0), 32'd0, 1'b0, 32'd2, 16'd5, SAT ? 2'd3 : 2'd1, 1'b1};
        tbl[7]  = '{1'b1, mk(MODE_WRITE, 32'h7FFFFFFF, 1'b0), 32'd0, 1'b0, 32'h7FFFFFFF, 16'd0, 2'd0, 1'b0};
        tbl[8]  = '{1'b0, mk(MODE_WRITE, 32'h7FFFFFFF, 1'b0), 32'h7FFFFFFF, 1'b0,
                    SAT ? 32'h7FFFFFFF : 32'hFFFFFFFE, 16'd0, 2'd0, 1'b1};
        tbl[9]  = '{1'b0, mk(MODE_WRITE, 32'h80000000, 1'b1), 32'h80000000, 1'b0,
                    SAT ? 32'h7FFFFFFF : 32'h7FFFFFFE, 16'd0, 2'd0, 1'b0};
        tbl[10] = '{1'b0, mk(MODE_WRITE, 32'h80000000, 1'b0), 32'd0, 1'b0,
                    SAT ? 32'hFFFFFFFF : 32'hFFFFFFFE, 16'd0, 2'd0, 1'b0};
        tbl[11] = '{1'b0, mk(MODE_WRITE, 32'hFFFFFFFA, 1'b1), 32'hFFFFFFFA, 1'b1,
                    SAT ? 32'd5 : 32'd4, 16'd0, 2'd0, 1'b1};

        // idle after reset
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_notify", 32'(b_in_notify), 32'd1);
            check("idle_res", 32'(res_notify), 32'd0);
            check("idle_acc", acc_out, 32'd0);
            check("idle_rd", 32'(rd_count), 32'd0);
            check("idle_match", 32'(match_out), 32'd0);
        end

        // directed vector table
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].rst_before) do_reset();
            send(tbl[i].rec, tbl[i].mx, tbl[i].my, 1'b0);
            check($sformatf("tbl%0d_acc", i), acc_out, tbl[i].e_acc);
            check($sformatf("tbl%0d_rd", i), 32'(rd_count), 32'(tbl[i].e_rd));
            check($sformatf("tbl%0d_rd2", i), 32'(rd_count_c2), 32'(tbl[i].e_rd2));
            check($sformatf("tbl%0d_match", i), 32'(match_out), 32'(tbl[i].e_match));
            tick();
            check($sformatf("tbl%0d_res_drop", i), 32'(res_notify), 32'd0);
        end

        // sync held high with read records: one transfer every second edge
        do_reset();
        b_in      = mk(MODE_READ, 32'd1, 1'b0);
        b_in_sync = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i % 2 == 0) begin
                check("cont_notify_low", 32'(b_in_notify), 32'd0);
                check("cont_res_low", 32'(res_notify), 32'd0);
            end else begin
                check("cont_res_high", 32'(res_notify), 32'd1);
                check("cont_rd", 32'(rd_count), 32'((i + 1) / 2));
            end
        end
        b_in_sync = 1'b0;
        tick();
        check("cont_rd_final", 32'(rd_count), 32'd4);
        check("cont_res_final", 32'(res_notify), 32'd0);

        // randomized records against the reference model
        do_reset();
        for (int n = 0; n < 150; n++) begin
            CompoundType r;
            logic [31:0] mx;
            logic        my;
            int          gap;
            r = junk_rec();
            case ($urandom_range(0, 5))
                0: r.x = 32'h80000000;
                1: r.x = 32'h7FFFFFFF;
                2: r.x = 32'($urandom_range(0, 20));
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1) begin
                mx = r.x;
                my = r.y;
            end else begin
                mx = ($urandom_range(0, 1) == 1) ? r.x : $urandom;
                my = 1'($urandom_range(0, 1));
            end
            send(r, mx, my, 1'($urandom_range(0, 1)));
            model_apply(r, mx, my);
            check("rnd_acc", acc_out, 32'(acc_m));
            check("rnd_rd", 32'(rd_count), exp_rd(rd_m, 65536));
            check("rnd_rd2", 32'(rd_count_c2), exp_rd(rd_m, 4));
            check("rnd_match", 32'(match_out), 32'(match_m));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                m_in = junk_rec();
                tick();
                check("rnd_idle_res", 32'(res_notify), 32'd0);
                check("rnd_idle_acc", acc_out, 32'(acc_m));
            end
        end

        // reset while a write of 9 is being processed
        if (b_in_notify !== 1'b1) tick();
        b_in      = mk(MODE_WRITE, 32'd9, 1'b0);
        b_in_sync = 1'b1;
        tick();
        b_in_sync = 1'b0;
        rst       = 1'b1;
        #2;
        check("rstmid_acc", acc_out, 32'd0);
        check("rstmid_res", 32'(res_notify), 32'd0);
        check("rstmid_rd", 32'(rd_count), 32'd0);
        check("rstmid_notify", 32'(b_in_notify), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        check("rstmid_acc_after", acc_out, 32'd0);
        check("rstmid_res_after", 32'(res_notify), 32'd0);
        check("rstmid_notify_after", 32'(b_in_notify), 32'd1);
        check("rstmid_match_after", 32'(match_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
